// File: rtl/combo_lock_ctrl.sv
// Combination lock sequencer: shifts keypad digits into four display nibbles,
// checks them against a stored code and times the open, error and lockout phases.
module combo_lock_ctrl #(
    parameter logic [15:0] CODE        = 16'h1234,
    parameter int          OPEN_CYCLES = 16,
    parameter int          ERR_CYCLES  = 8,
    parameter int          LOCK_CYCLES = 32,
    parameter int          MAX_FAILS   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    input  logic       enter,
    input  logic       clear,
    input  logic       relock,
    output logic [3:0] disp3,
    output logic [3:0] disp2,
    output logic [3:0] disp1,
    output logic [3:0] disp0,
    output logic [2:0] entry_cnt,
    output logic       unlocked,
    output logic       err,
    output logic       lockout
);

    localparam int MAX_OE = (OPEN_CYCLES > ERR_CYCLES) ? OPEN_CYCLES : ERR_CYCLES;
    localparam int MAX_C  = (MAX_OE > LOCK_CYCLES) ? MAX_OE : LOCK_CYCLES;
    localparam int TW     = $clog2(MAX_C + 1);
    localparam int FW     = $clog2(MAX_FAILS + 1);

    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] ERR_LOAD  = TW'(ERR_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_LIM  = FW'(MAX_FAILS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_ERROR   = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [15:0]   disp_r, disp_s;
    logic [2:0]    cnt_r, cnt_s;
    logic [15:0]   code_r, code_s;
    logic [FW-1:0] fails_r, fails_s;
    logic [TW-1:0] timer_r, timer_s;
    logic          unlocked_r, err_r, lockout_r;

    logic          digit_ok_s;
    logic [15:0]   shifted_s;
    logic [2:0]    cnt_inc_s;
    logic [FW-1:0] fails_inc_s;
    logic [TW-1:0] timer_dec_s;

    // Next-state, display, counter and timer logic; the winning input of a cycle takes all.
    always_comb begin
        state_s     = state_r;
        disp_s      = disp_r;
        cnt_s       = cnt_r;
        code_s      = code_r;
        fails_s     = fails_r;
        timer_s     = timer_r;
        digit_ok_s  = digit_valid && (digit_in <= 4'd9);
        shifted_s   = {disp_r[11:0], digit_in};
        cnt_inc_s   = (cnt_r == 3'd4) ? 3'd4 : (cnt_r + 3'd1);
        fails_inc_s = fails_r + FW'(1);
        timer_dec_s = (timer_r == TW'(0)) ? TW'(0) : (timer_r - TW'(1));

        case (state_r)
            ST_IDLE: begin
                if (!clear && !enter && digit_ok_s) begin
                    disp_s  = shifted_s;
                    cnt_s   = cnt_inc_s;
                    state_s = ST_ENTRY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                if (clear) begin
                    disp_s  = 16'h0000;
                    cnt_s   = 3'd0;
                    state_s = ST_IDLE;
                end else if (enter) begin
                    cnt_s = 3'd0;
                    if ((cnt_r == 3'd4) && (disp_r == code_r)) begin
                        state_s = ST_OPEN;
                        fails_s = FW'(0);
                        disp_s  = 16'h0000;
                        timer_s = OPEN_LOAD;
                    end else if (fails_inc_s == FAIL_LIM) begin
                        fails_s = fails_inc_s;
                        state_s = ST_LOCKOUT;
                        disp_s  = 16'hFFFF;
                        timer_s = LOCK_LOAD;
                    end else begin
                        fails_s = fails_inc_s;
                        state_s = ST_ERROR;
                        disp_s  = 16'hEEEE;
                        timer_s = ERR_LOAD;
                    end
                end else if (digit_ok_s) begin
                    disp_s = shifted_s;
                    cnt_s  = cnt_inc_s;
                end else begin
                    state_s = ST_ENTRY;
                end
            end
            ST_OPEN: begin
                if (relock || (timer_r == TW'(0))) begin
                    state_s = ST_IDLE;
                    disp_s  = 16'h0000;
                    cnt_s   = 3'd0;
                end else if (clear) begin
                    disp_s  = 16'h0000;
                    cnt_s   = 3'd0;
                    timer_s = OPEN_LOAD;
                end else if (enter) begin
                    if (cnt_r == 3'd4) begin
                        code_s  = disp_r;
                        disp_s  = 16'h0000;
                        cnt_s   = 3'd0;
                        timer_s = OPEN_LOAD;
                    end else begin
                        timer_s = timer_dec_s;
                    end
                end else if (digit_ok_s) begin
                    disp_s  = shifted_s;
                    cnt_s   = cnt_inc_s;
                    timer_s = OPEN_LOAD;
                end else begin
                    timer_s = timer_dec_s;
                end
            end
            ST_ERROR, ST_LOCKOUT: begin
                if (timer_r == TW'(0)) begin
                    state_s = ST_IDLE;
                    disp_s  = 16'h0000;
                    if (state_r == ST_LOCKOUT) begin
                        fails_s = FW'(0);
                    end else begin
                        fails_s = fails_r;
                    end
                end else begin
                    timer_s = timer_dec_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
                disp_s  = 16'h0000;
                cnt_s   = 3'd0;
                timer_s = TW'(0);
            end
        endcase
    end

    // State and output registers; flags are decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            disp_r     <= 16'h0000;
            cnt_r      <= 3'd0;
            code_r     <= CODE;
            fails_r    <= FW'(0);
            timer_r    <= TW'(0);
            unlocked_r <= 1'b0;
            err_r      <= 1'b0;
            lockout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            disp_r     <= disp_s;
            cnt_r      <= cnt_s;
            code_r     <= code_s;
            fails_r    <= fails_s;
            timer_r    <= timer_s;
            unlocked_r <= (state_s == ST_OPEN);
            err_r      <= (state_s == ST_ERROR);
            lockout_r  <= (state_s == ST_LOCKOUT);
        end
    end

    assign disp3     = disp_r[15:12];
    assign disp2     = disp_r[11:8];
    assign disp1     = disp_r[7:4];
    assign disp0     = disp_r[3:0];
    assign entry_cnt = cnt_r;
    assign unlocked  = unlocked_r;
    assign err       = err_r;
    assign lockout   = lockout_r;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Self-checking bench for combo_lock_ctrl: directed test-plan sequences with literal
// expectations, then randomized pulses compared every cycle against a behavioural model.
module tb_combo_lock_ctrl;

    localparam logic [15:0] CODE   = 16'h1234;
    localparam int          OPEN_C = 16;
    localparam int          ERR_C  = 8;
    localparam int          LOCK_C = 32;
    localparam int          MAXF   = 3;

    localparam int P_IDLE = 0, P_ENTRY = 1, P_OPEN = 2, P_ERROR = 3, P_LOCK = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digit_in = 4'd0;
    logic       digit_valid = 1'b0;
    logic       enter = 1'b0;
    logic       clear = 1'b0;
    logic       relock = 1'b0;
    logic [3:0] disp3, disp2, disp1, disp0;
    logic [2:0] entry_cnt;
    logic       unlocked, err, lockout;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    combo_lock_ctrl #(
        .CODE(CODE), .OPEN_CYCLES(OPEN_C), .ERR_CYCLES(ERR_C),
        .LOCK_CYCLES(LOCK_C), .MAX_FAILS(MAXF)
    ) dut (
        .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
        .enter(enter), .clear(clear), .relock(relock),
        .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0),
        .entry_cnt(entry_cnt), .unlocked(unlocked), .err(err), .lockout(lockout)
    );

    always #5 clk = ~clk;

    // Behavioural model: digit list (index 0 = leftmost), phase, cycles left in the phase.
    int m_d[4];
    int m_code[4];
    int m_cnt, m_fails, m_phase, m_left;

    function automatic logic [15:0] m_disp();
        return {4'(m_d[0]), 4'(m_d[1]), 4'(m_d[2]), 4'(m_d[3])};
    endfunction

    function automatic logic [2:0] m_flags();
        return {m_phase == P_OPEN, m_phase == P_ERROR, m_phase == P_LOCK};
    endfunction

    task automatic m_fill(input int v);
        for (int i = 0; i < 4; i++) m_d[i] = v;
    endtask

    task automatic m_push(input int v);
        for (int i = 0; i < 3; i++) m_d[i] = m_d[i+1];
        m_d[3] = v;
        m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
    endtask

    task automatic model_step();
        bit dig;
        bit match;
        dig = digit_valid && (int'(digit_in) < 10);
        if (rst) begin
            m_fill(0);
            for (int i = 0; i < 4; i++) m_code[i] = int'(CODE >> (12 - 4*i)) & 15;
            m_cnt = 0; m_fails = 0; m_phase = P_IDLE; m_left = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (!clear && !enter && dig) begin
                    m_push(int'(digit_in)); m_phase = P_ENTRY;
                end
                P_ENTRY: begin
                    if (clear) begin
                        m_fill(0); m_cnt = 0; m_phase = P_IDLE;
                    end else if (enter) begin
                        match = (m_cnt == 4);
                        for (int i = 0; i < 4; i++) if (m_d[i] != m_code[i]) match = 0;
                        m_cnt = 0;
                        if (match) begin
                            m_phase = P_OPEN; m_fails = 0; m_fill(0); m_left = OPEN_C;
                        end else begin
                            m_fails++;
                            if (m_fails == MAXF) begin
                                m_phase = P_LOCK; m_fill(15); m_left = LOCK_C;
                            end else begin
                                m_phase = P_ERROR; m_fill(14); m_left = ERR_C;
                            end
                        end
                    end else if (dig) begin
                        m_push(int'(digit_in));
                    end
                end
                P_OPEN: begin
                    if (relock || m_left == 1) begin
                        m_phase = P_IDLE; m_fill(0); m_cnt = 0;
                    end else begin
                        m_left--;
                        if (clear) begin
                            m_fill(0); m_cnt = 0; m_left = OPEN_C;
                        end else if (enter) begin
                            if (m_cnt == 4) begin
                                for (int i = 0; i < 4; i++) m_code[i] = m_d[i];
                                m_fill(0); m_cnt = 0; m_left = OPEN_C;
                            end
                        end else if (dig) begin
                            m_push(int'(digit_in)); m_left = OPEN_C;
                        end
                    end
                end
                default: begin
                    if (m_left == 1) begin
                        if (m_phase == P_LOCK) m_fails = 0;
                        m_phase = P_IDLE; m_fill(0);
                    end else begin
                        m_left--;
                    end
                end
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({disp3, disp2, disp1, disp0} !== m_disp() || entry_cnt !== 3'(m_cnt) ||
                {unlocked, err, lockout} !== m_flags() ||
                (int'(unlocked) + int'(err) + int'(lockout)) > 1) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t got disp=%h cnt=%0d flags=%b want disp=%h cnt=%0d flags=%b",
                         $time, {disp3, disp2, disp1, disp0}, entry_cnt, {unlocked, err, lockout},
                         m_disp(), m_cnt, m_flags());
            end
        end
    end

    task automatic expect_out(input string nm, input logic [15:0] de, input logic [2:0] ce,
                              input logic [2:0] fe);
        checks++;
        if ({disp3, disp2, disp1, disp0} !== de || entry_cnt !== ce || {unlocked, err, lockout} !== fe) begin
            failures++;
            $display("FAIL %s got disp=%h cnt=%0d flags=%b want disp=%h cnt=%0d flags=%b", nm,
                     {disp3, disp2, disp1, disp0}, entry_cnt, {unlocked, err, lockout}, de, ce, fe);
        end
        checks++;
        if (m_disp() !== de || 3'(m_cnt) !== ce || m_flags() !== fe) begin
            failures++;
            $display("FAIL %s_model got disp=%h cnt=%0d flags=%b want disp=%h cnt=%0d flags=%b", nm,
                     m_disp(), m_cnt, m_flags(), de, ce, fe);
        end
    endtask

    task automatic step(input logic dv, input logic [3:0] d, input logic en, input logic cl,
                        input logic rl);
        digit_valid = dv; digit_in = d; enter = en; clear = cl; relock = rl;
        @(negedge clk);
        digit_valid = 1'b0; enter = 1'b0; clear = 1'b0; relock = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic digits4(input logic [15:0] v);
        for (int i = 0; i < 4; i++) step(1'b1, 4'(v >> (12 - 4*i)), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_enter();
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int r;
        logic dv, en, cl, rl;
        logic [3:0] d;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        expect_out("reset", 16'h0000, 3'd0, 3'b000);

        // Correct code opens for exactly OPEN_C cycles.
        digits4(16'h1234);
        expect_out("entry4", 16'h1234, 3'd4, 3'b000);
        do_enter();
        expect_out("open", 16'h0000, 3'd0, 3'b100);
        idle(OPEN_C - 1);
        expect_out("open_last", 16'h0000, 3'd0, 3'b100);
        idle(1);
        expect_out("open_expired", 16'h0000, 3'd0, 3'b000);

        // Wrong entries: error twice, then lockout; digits ignored in lockout.
        digits4(16'h1235);
        do_enter();
        expect_out("err1", 16'hEEEE, 3'd0, 3'b010);
        idle(ERR_C - 1);
        expect_out("err_last", 16'hEEEE, 3'd0, 3'b010);
        idle(1);
        expect_out("err_done", 16'h0000, 3'd0, 3'b000);
        digits4(16'h1235);
        do_enter();
        expect_out("err2", 16'hEEEE, 3'd0, 3'b010);
        idle(ERR_C);
        digits4(16'h1235);
        do_enter();
        expect_out("lockout", 16'hFFFF, 3'd0, 3'b001);
        step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        expect_out("lock_digit", 16'hFFFF, 3'd0, 3'b001);
        idle(LOCK_C - 2);
        expect_out("lock_last", 16'hFFFF, 3'd0, 3'b001);
        idle(1);
        expect_out("lock_done", 16'h0000, 3'd0, 3'b000);

        // Last four digits count; short entry is wrong.
        step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
        digits4(16'h1234);
        expect_out("five_digits", 16'h1234, 3'd4, 3'b000);
        do_enter();
        expect_out("open_last4", 16'h0000, 3'd0, 3'b100);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        expect_out("relock", 16'h0000, 3'd0, 3'b000);
        step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        expect_out("short", 16'h0012, 3'd2, 3'b000);
        do_enter();
        expect_out("short_err", 16'hEEEE, 3'd0, 3'b010);
        idle(ERR_C);

        // Code change while open, then reset restores the default code.
        digits4(16'h1234);
        do_enter();
        digits4(16'h5678);
        expect_out("open_digits", 16'h5678, 3'd4, 3'b100);
        do_enter();
        expect_out("code_store", 16'h0000, 3'd0, 3'b100);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        digits4(16'h1234);
        do_enter();
        expect_out("old_code_err", 16'hEEEE, 3'd0, 3'b010);
        idle(ERR_C);
        digits4(16'h5678);
        do_enter();
        expect_out("new_code_open", 16'h0000, 3'd0, 3'b100);
        pulse_rst();
        expect_out("rst_open", 16'h0000, 3'd0, 3'b000);
        digits4(16'h1234);
        do_enter();
        expect_out("code_reverted", 16'h0000, 3'd0, 3'b100);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // Clear beats enter and digit; illegal digit ignored; clear counts no fail.
        step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
        expect_out("clear_wins", 16'h0000, 3'd0, 3'b000);
        step(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
        expect_out("digit_b", 16'h0000, 3'd0, 3'b000);
        step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        expect_out("digit_7", 16'h0007, 3'd1, 3'b000);
        do_enter();
        idle(ERR_C);
        step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        do_enter();
        expect_out("no_fail_clear", 16'hEEEE, 3'd0, 3'b010);
        idle(ERR_C);
        step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        do_enter();
        expect_out("lock_again", 16'hFFFF, 3'd0, 3'b001);
        idle(5);
        pulse_rst();
        expect_out("rst_lock", 16'h0000, 3'd0, 3'b000);

        // Randomized pulses; occasionally key in the model's current code.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_rst();
            end else if ($urandom_range(0, 24) == 0 && (m_phase == P_IDLE || m_phase == P_ENTRY)) begin
                for (int k = 0; k < 4; k++) step(1'b1, 4'(m_code[k]), 1'b0, 1'b0, 1'b0);
                do_enter();
            end else begin
                r  = int'($urandom_range(0, 99));
                dv = (r < 45);
                en = ($urandom_range(0, 99) < 10);
                cl = ($urandom_range(0, 99) < 5);
                rl = ($urandom_range(0, 99) < 5);
                d  = 4'($urandom_range(0, 15));
                step(dv, d, en, cl, rl);
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
